mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_stage_pkg.sv | 11 +
 rtl/mem_timeout_ctr.sv | 27 ++
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared state encoding and sizing defaults for the memory-access pipeline stage.
package mem_stage_pkg;
    localparam int DATA_W          = 16;
    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts WAIT cycles; expired flags the last WAIT cycle allowed before an abort.
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Count is 0 in the first WAIT cycle, so TIMEOUT-1 marks the TIMEOUT-th one.
    assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU ops through in one cycle, runs loads/stores over a
// req/ack data-memory port with a bounded wait and a sticky timeout error.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = mem_stage_pkg::DATA_W,
    parameter int TIMEOUT = mem_stage_pkg::TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              regWrite,
    input  logic              r0Write,
    input  logic              memSource,
    input  logic [3:0]        RA1,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [DATA_W-1:0] R0D,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              stall_o,
    output logic              out_valid,
    output logic              regWrite_o,
    output logic              r0Write_o,
    output logic              memSource_o,
    output logic [3:0]        RA1_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] DataIn_o,
    output logic [DATA_W-1:0] R0D_o,
    output logic              mem_err_o
);
    state_t            state_reg, state_next;
    logic              expired, ctr_clear, ctr_enable;
    logic              pass_op, start_op, done_ack, done_timeout, finish_op, kill_now;
    logic              regwrite_cap_reg, r0write_cap_reg, memsource_cap_reg;
    logic              load_cap_reg, killed_reg;
    logic [3:0]        ra1_cap_reg;
    logic [DATA_W-1:0] r0d_cap_reg;

    assign ctr_clear  = (state_reg == IDLE);
    assign ctr_enable = (state_reg == WAIT);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (expired)
    );

    assign stall_o   = (state_reg == WAIT);
    assign finish_op = done_ack | done_timeout;
    assign kill_now  = killed_reg | flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pass_op      = 1'b0;
        start_op     = 1'b0;
        done_ack     = 1'b0;
        done_timeout = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (memRead || memWrite) begin
                        start_op   = 1'b1;
                        state_next = WAIT;
                    end else begin
                        pass_op = 1'b1;
                    end
                end
            end
            WAIT: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (dm_ack) begin
                    done_ack   = 1'b1;
                    state_next = IDLE;
                end else if (expired) begin
                    done_timeout = 1'b1;
                    state_next   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dm_req            <= 1'b0;
            dm_we             <= 1'b0;
            dm_addr           <= '0;
            dm_wdata          <= '0;
            out_valid         <= 1'b0;
            regWrite_o        <= 1'b0;
            r0Write_o         <= 1'b0;
            memSource_o       <= 1'b0;
            RA1_o             <= '0;
            ALUResult_o       <= '0;
            DataIn_o          <= '0;
            R0D_o             <= '0;
            mem_err_o         <= 1'b0;
            regwrite_cap_reg  <= 1'b0;
            r0write_cap_reg   <= 1'b0;
            memsource_cap_reg <= 1'b0;
            load_cap_reg      <= 1'b0;
            killed_reg        <= 1'b0;
            ra1_cap_reg       <= '0;
            r0d_cap_reg       <= '0;
        end else begin
            out_valid  <= 1'b0;
            regWrite_o <= 1'b0;
            r0Write_o  <= 1'b0;
            if (pass_op) begin
                out_valid   <= 1'b1;
                regWrite_o  <= regWrite;
                r0Write_o   <= r0Write;
                memSource_o <= memSource;
                RA1_o       <= RA1;
                ALUResult_o <= ALUResult;
                DataIn_o    <= '0;
                R0D_o       <= R0D;
            end
            if (start_op) begin
                dm_req            <= 1'b1;
                dm_we             <= memWrite;
                dm_addr           <= ALUResult;
                dm_wdata          <= StoreData;
                regwrite_cap_reg  <= regWrite;
                r0write_cap_reg   <= r0Write;
                memsource_cap_reg <= memSource;
                load_cap_reg      <= memRead & ~memWrite;
                killed_reg        <= 1'b0;
                ra1_cap_reg       <= RA1;
                r0d_cap_reg       <= R0D;
            end
            if (state_reg == WAIT && flush) begin
                killed_reg <= 1'b1;
            end
            if (finish_op) begin
                dm_req <= 1'b0;
                dm_we  <= 1'b0;
                if (done_timeout) begin
                    mem_err_o <= 1'b1;
                end
                // A killed instruction still finishes its access but never reaches MEM/WB.
                if (!kill_now) begin
                    out_valid   <= 1'b1;
                    regWrite_o  <= done_ack & regwrite_cap_reg;
                    r0Write_o   <= done_ack & r0write_cap_reg;
                    memSource_o <= memsource_cap_reg;
                    RA1_o       <= ra1_cap_reg;
                    ALUResult_o <= dm_addr;
                    DataIn_o    <= (done_ack && load_cap_reg) ? dm_rdata : '0;
                    R0D_o       <= r0d_cap_reg;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a queue scoreboard of expected MEM/WB outputs.
module tb_mem_access_stage;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, flush, memRead, memWrite, regWrite, r0Write, memSource;
    logic [3:0]        RA1;
    logic [DATA_W-1:0] ALUResult, StoreData, R0D;
    logic              dm_req, dm_we, dm_ack;
    logic [DATA_W-1:0] dm_addr, dm_wdata, dm_rdata;
    logic              stall_o, out_valid, regWrite_o, r0Write_o, memSource_o, mem_err_o;
    logic [3:0]        RA1_o;
    logic [DATA_W-1:0] ALUResult_o, DataIn_o, R0D_o;

    typedef struct {
        logic              rw;
        logic              r0w;
        logic              ms;
        logic [3:0]        ra1;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] r0d;
        int                due;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    mem_access_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .r0Write(r0Write),
        .memSource(memSource), .RA1(RA1), .ALUResult(ALUResult), .StoreData(StoreData),
        .R0D(R0D), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_o(stall_o), .out_valid(out_valid),
        .regWrite_o(regWrite_o), .r0Write_o(r0Write_o), .memSource_o(memSource_o),
        .RA1_o(RA1_o), .ALUResult_o(ALUResult_o), .DataIn_o(DataIn_o), .R0D_o(R0D_o),
        .mem_err_o(mem_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic set_idle();
        in_valid = 0; flush = 0; memRead = 0; memWrite = 0; regWrite = 0; r0Write = 0;
        memSource = 0; RA1 = '0; ALUResult = '0; StoreData = '0; R0D = '0;
        dm_ack = 0; dm_rdata = '0;
    endtask

    task automatic drive_op(input logic mr, input logic mw, input logic rw, input logic r0w,
                            input logic ms, input logic [3:0] ra1, input logic [15:0] alu,
                            input logic [15:0] sd, input logic [15:0] r0d);
        in_valid = 1; flush = 0; memRead = mr; memWrite = mw; regWrite = rw; r0Write = r0w;
        memSource = ms; RA1 = ra1; ALUResult = alu; StoreData = sd; R0D = r0d;
    endtask

    task automatic push_exp(input logic rw, input logic r0w, input logic ms, input logic [3:0] ra1,
                            input logic [15:0] alu, input logic [15:0] din,
                            input logic [15:0] r0d, input int due);
        exp_t e;
        e.rw = rw; e.r0w = r0w; e.ms = ms; e.ra1 = ra1;
        e.alu = alu; e.din = din; e.r0d = r0d; e.due = due;
        sb_q.push_back(e);
    endtask

    task automatic expect_wait(input string tag, input logic [15:0] addr, input logic we);
        check({tag, "_stall"}, 32'(stall_o), 32'd1);
        check({tag, "_req"}, 32'(dm_req), 32'd1);
        check({tag, "_we"}, 32'(dm_we), 32'(we));
        check({tag, "_addr"}, 32'(dm_addr), 32'(addr));
    endtask

    // Output monitor: every out_valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_cycle", 32'(cyc), 32'(e.due));
                    check("regWrite_o", 32'(regWrite_o), 32'(e.rw));
                    check("r0Write_o", 32'(r0Write_o), 32'(e.r0w));
                    check("memSource_o", 32'(memSource_o), 32'(e.ms));
                    check("RA1_o", 32'(RA1_o), 32'(e.ra1));
                    check("ALUResult_o", 32'(ALUResult_o), 32'(e.alu));
                    check("DataIn_o", 32'(DataIn_o), 32'(e.din));
                    check("R0D_o", 32'(R0D_o), 32'(e.r0d));
                    $display("txn: RA1_o=%0d ALUResult_o=%h DataIn_o=%h at cycle %0d",
                             RA1_o, ALUResult_o, DataIn_o, cyc);
                end
            end else begin
                check("bubble_writes", 32'({regWrite_o, r0Write_o}), 32'd0);
            end
        end
    end

    initial begin
        reset = 0;
        set_idle();
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_dm_req", 32'(dm_req), 32'd0);
        check("rst_mem_err", 32'(mem_err_o), 32'd0);
        check("rst_alu_o", 32'(ALUResult_o), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        reset = 1;

        // ALU pass-through, two patterns back to back
        @(negedge clk);
        drive_op(0, 0, 1, 0, 0, 4'd3, 16'h0005, 16'h0000, 16'h00AA);
        push_exp(1, 0, 0, 4'd3, 16'h0005, 16'h0000, 16'h00AA, cyc + 1);
        @(negedge clk);
        check("alu_stall", 32'(stall_o), 32'd0);
        drive_op(0, 0, 0, 1, 1, 4'd7, 16'hA5A5, 16'h2222, 16'h1111);
        push_exp(0, 1, 1, 4'd7, 16'hA5A5, 16'h0000, 16'h1111, cyc + 1);
        @(negedge clk);
        // flushed ALU op and flushed load in IDLE are both dropped
        drive_op(0, 0, 1, 1, 0, 4'd1, 16'h1234, 16'h0, 16'h0);
        flush = 1;
        @(negedge clk);
        drive_op(1, 0, 1, 1, 0, 4'd1, 16'h4321, 16'h0, 16'h0);
        flush = 1;
        @(negedge clk);
        check("flush_idle_valid", 32'(out_valid), 32'd0);
        check("flush_idle_stall", 32'(stall_o), 32'd0);
        set_idle();
        // ack outside WAIT is ignored
        dm_ack = 1; dm_rdata = 16'h7E7E;
        @(negedge clk);
        check("stray_ack_stall", 32'(stall_o), 32'd0);
        set_idle();

        // Load, ack in the 3rd WAIT cycle, in_valid toggling meanwhile must be ignored
        @(negedge clk);
        drive_op(1, 0, 1, 0, 1, 4'd5, 16'h0040, 16'hFFFF, 16'h0F0F);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive_op(0, 0, 1, 1, 0, 4'd9, 16'h9999, 16'h8888, 16'h7777);
            expect_wait("load", 16'h0040, 1'b0);
            if (k == 3) begin
                dm_ack = 1; dm_rdata = 16'hBEEF;
                push_exp(1, 0, 1, 4'd5, 16'h0040, 16'hBEEF, 16'h0F0F, cyc + 1);
            end
        end
        @(negedge clk);
        set_idle();
        check("load_end_stall", 32'(stall_o), 32'd0);
        check("load_end_req", 32'(dm_req), 32'd0);

        // Store with ack in first WAIT cycle: out_valid two edges after capture
        drive_op(0, 1, 1, 1, 0, 4'd6, 16'h0010, 16'h1234, 16'h00C3);
        @(negedge clk);
        set_idle();
        expect_wait("store", 16'h0010, 1'b1);
        check("store_wdata", 32'(dm_wdata), 32'h1234);
        dm_ack = 1; dm_rdata = 16'hDEAD;
        push_exp(1, 1, 0, 4'd6, 16'h0010, 16'h0000, 16'h00C3, cyc + 1);
        @(negedge clk);
        set_idle();

        // memRead and memWrite together behave as a store
        drive_op(1, 1, 1, 0, 1, 4'd8, 16'h0020, 16'h5A5A, 16'h0101);
        @(negedge clk);
        set_idle();
        expect_wait("rdwr", 16'h0020, 1'b1);
        check("rdwr_wdata", 32'(dm_wdata), 32'h5A5A);
        dm_ack = 1; dm_rdata = 16'h5555;
        push_exp(1, 0, 1, 4'd8, 16'h0020, 16'h0000, 16'h0101, cyc + 1);
        @(negedge clk);
        set_idle();

        // Ack in the final allowed WAIT cycle completes normally
        drive_op(1, 0, 1, 0, 0, 4'd10, 16'h0123, 16'h0, 16'h0202);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            set_idle();
            expect_wait("late_ack", 16'h0123, 1'b0);
            if (k == TIMEOUT) begin
                dm_ack = 1; dm_rdata = 16'hCAFE;
                push_exp(1, 0, 0, 4'd10, 16'h0123, 16'hCAFE, 16'h0202, cyc + 1);
            end
        end
        @(negedge clk);
        set_idle();
        check("late_ack_err", 32'(mem_err_o), 32'd0);

        // Timeout: bubble with writes cleared, sticky error, next op accepted
        drive_op(1, 0, 1, 1, 1, 4'd11, 16'h0077, 16'h0, 16'h0303);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            set_idle();
            expect_wait("tmo", 16'h0077, 1'b0);
            check("tmo_err_pending", 32'(mem_err_o), 32'd0);
            if (k == TIMEOUT)
                push_exp(0, 0, 1, 4'd11, 16'h0077, 16'h0000, 16'h0303, cyc + 1);
        end
        @(negedge clk);
        check("tmo_stall", 32'(stall_o), 32'd0);
        check("tmo_err", 32'(mem_err_o), 32'd1);
        drive_op(0, 0, 1, 0, 0, 4'd12, 16'h0ABC, 16'h0, 16'h0404);
        push_exp(1, 0, 0, 4'd12, 16'h0ABC, 16'h0000, 16'h0404, cyc + 1);
        @(negedge clk);
        set_idle();
        check("tmo_err_sticky", 32'(mem_err_o), 32'd1);

        // Flush during WAIT: access completes but produces no output
        drive_op(0, 1, 1, 1, 0, 4'd13, 16'h0022, 16'h3333, 16'h0505);
        @(negedge clk);
        set_idle();
        expect_wait("flush_w1", 16'h0022, 1'b1);
        flush = 1;
        @(negedge clk);
        flush = 0;
        expect_wait("flush_w2", 16'h0022, 1'b1);
        @(negedge clk);
        expect_wait("flush_w3", 16'h0022, 1'b1);
        dm_ack = 1;
        @(negedge clk);
        set_idle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_stall", 32'(stall_o), 32'd0);
        check("flush_hold_alu", 32'(ALUResult_o), 32'h0ABC);

        // Reset mid-WAIT clears everything without a clock edge
        drive_op(1, 0, 1, 0, 0, 4'd14, 16'h0044, 16'h0, 16'h0606);
        @(negedge clk);
        set_idle();
        expect_wait("rstw", 16'h0044, 1'b0);
        #2 reset = 0;
        #1;
        check("rstw_stall", 32'(stall_o), 32'd0);
        check("rstw_req", 32'(dm_req), 32'd0);
        check("rstw_addr", 32'(dm_addr), 32'd0);
        check("rstw_err", 32'(mem_err_o), 32'd0);
        check("rstw_alu_o", 32'(ALUResult_o), 32'd0);
        check("rstw_r0d_o", 32'(R0D_o), 32'd0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        drive_op(0, 0, 1, 1, 1, 4'd2, 16'h00FF, 16'h0, 16'h0707);
        push_exp(1, 1, 1, 4'd2, 16'h00FF, 16'h0000, 16'h0707, cyc + 1);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
